// File: rtl/cpu_types_pkg.sv
// Core-wide types shared by every pipeline stage: machine word and primary opcodes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Pipeline control types: next-PC select and fetch-stage state encoding.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } PCSrc_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch-target buffer with full tags; present only when FETCH_BTB_EN is defined.
`ifdef FETCH_BTB_EN
module fetch_btb
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 4
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  word_t i_lookup_pc,
    input  logic  i_wen,
    input  word_t i_wpc,
    input  word_t i_wtarget,
    output logic  o_hit,
    output word_t o_target
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] r_valid;
    word_t              r_tag    [ENTRIES];
    word_t              r_target [ENTRIES];
    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;

    assign w_rd_idx = i_lookup_pc[IDX_W+1:2];
    assign w_wr_idx = i_wpc[IDX_W+1:2];
    assign o_hit    = r_valid[w_rd_idx] & (r_tag[w_rd_idx] == i_lookup_pc);
    assign o_target = r_target[w_rd_idx];

    // Valid bits: cleared on reset, set on update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wen) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag and target storage need no reset; a clear valid bit masks them
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_tag[w_wr_idx]    <= i_wpc;
            r_target[w_wr_idx] <= i_wtarget;
        end
    end

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-memory request and IF/ID latch.
// Define FETCH_BTB_EN to add the branch-target buffer (fetch_btb) for PC_NEXT prediction.
module fetch_stage
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter word_t PC_INIT     = 32'h0000_0000,
    parameter int    BTB_ENTRIES = 4
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   pc_en,
    input  logic   pipe1_en,
    input  logic   flushed1,
    input  PCSrc_t pc_src,
    input  word_t  branch_addr,
    input  word_t  jump_addr,
    input  word_t  jr_addr,
    input  logic   ihit,
    input  word_t  imemload,
    output logic   imemREN,
    output word_t  imemaddr,
    output word_t  ifid_instr,
    output word_t  ifid_npc,
    output logic   ifid_valid,
    output logic   ifid_pred_taken,
    input  logic   btb_wen,
    input  word_t  btb_pc,
    input  word_t  btb_target
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    word_t        r_pc;
    word_t        w_pc_plus4;
    word_t        w_pc_next;
    word_t        w_btb_target;
    logic         w_btb_hit;
    logic         w_fetch_valid;
    logic         w_redirect;
    logic         w_halt_load;
    logic         w_pc_load;

`ifdef FETCH_BTB_EN
    fetch_btb #(
        .ENTRIES     (BTB_ENTRIES)
    ) u_btb (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_lookup_pc (r_pc),
        .i_wen       (btb_wen),
        .i_wpc       (btb_pc),
        .i_wtarget   (btb_target),
        .o_hit       (w_btb_hit),
        .o_target    (w_btb_target)
    );
`else
    logic w_unused_btb;
    assign w_unused_btb = ^{btb_wen, btb_pc, btb_target, BTB_ENTRIES[0]};
    assign w_btb_hit    = 1'b0;
    assign w_btb_target = w_pc_plus4;
`endif

    assign imemaddr      = r_pc;
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_fetch_valid = ihit & (r_state == FETCH);
    assign w_redirect    = pc_en & (pc_src != PC_NEXT);
    assign w_halt_load   = pipe1_en & ~flushed1 & w_fetch_valid & (imemload[31:26] == HALT);
    // A halted PC only moves again when the halt itself is flushed as wrong-path
    assign w_pc_load     = pc_en & ((r_state != HALTED) | flushed1);

    // Next-PC selection
    always_comb begin
        w_pc_next = w_pc_plus4;
        case (pc_src)
            PC_NEXT: begin
                if (w_btb_hit) begin
                    w_pc_next = w_btb_target;
                end else begin
                    w_pc_next = w_pc_plus4;
                end
            end
            PC_BRANCH: w_pc_next = branch_addr;
            PC_JUMP:   w_pc_next = jump_addr;
            PC_JR:     w_pc_next = jr_addr;
            default:   w_pc_next = w_pc_plus4;
        endcase
    end

    // Fetch FSM next state and request enable
    always_comb begin
        w_state_next = r_state;
        imemREN      = 1'b1;
        case (r_state)
            FETCH: begin
                if (w_halt_load) begin
                    w_state_next = HALTED;
                end else if (w_redirect & ~ihit) begin
                    w_state_next = SQUASH;
                end else begin
                    w_state_next = FETCH;
                end
            end
            SQUASH: begin
                if (ihit) begin
                    w_state_next = FETCH;
                end else begin
                    w_state_next = SQUASH;
                end
            end
            HALTED: begin
                imemREN = 1'b0;
                if (flushed1) begin
                    w_state_next = FETCH;
                end else begin
                    w_state_next = HALTED;
                end
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // State, PC and IF/ID latch registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= FETCH;
            r_pc            <= PC_INIT;
            ifid_instr      <= 32'h0000_0000;
            ifid_npc        <= 32'h0000_0000;
            ifid_valid      <= 1'b0;
            ifid_pred_taken <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_load) begin
                r_pc <= w_pc_next;
            end
            if (flushed1) begin
                ifid_instr      <= 32'h0000_0000;
                ifid_npc        <= 32'h0000_0000;
                ifid_valid      <= 1'b0;
                ifid_pred_taken <= 1'b0;
            end else if (pipe1_en) begin
                ifid_instr      <= w_fetch_valid ? imemload : 32'h0000_0000;
                ifid_npc        <= w_pc_plus4;
                ifid_valid      <= w_fetch_valid;
                ifid_pred_taken <= w_fetch_valid & w_btb_hit;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; adds a BTB sequence when FETCH_BTB_EN is defined.
module tb_fetch_stage;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    logic   CLK = 1'b0;
    logic   RST;
    logic   pc_en, pipe1_en, flushed1, ihit, btb_wen;
    PCSrc_t pc_src;
    word_t  branch_addr, jump_addr, jr_addr, imemload, btb_pc, btb_target;
    logic   imemREN, ifid_valid, ifid_pred_taken;
    word_t  imemaddr, ifid_instr, ifid_npc;

    int n_checks = 0;
    int n_errors = 0;

    localparam word_t HALT_W = 32'hFC00_0000;

    fetch_stage #(.PC_INIT(32'h0000_0000), .BTB_ENTRIES(4)) dut (
        .CLK(CLK), .RST(RST), .pc_en(pc_en), .pipe1_en(pipe1_en), .flushed1(flushed1),
        .pc_src(pc_src), .branch_addr(branch_addr), .jump_addr(jump_addr), .jr_addr(jr_addr),
        .ihit(ihit), .imemload(imemload), .imemREN(imemREN), .imemaddr(imemaddr),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
        .ifid_pred_taken(ifid_pred_taken), .btb_wen(btb_wen), .btb_pc(btb_pc),
        .btb_target(btb_target)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic   rst, pe, p1, fl;
        PCSrc_t src;
        word_t  tgt;
        logic   hit;
        word_t  ins;
        logic   e_ren;
        word_t  e_addr, e_ins, e_npc;
        logic   e_v;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic rst, pe, p1, fl, input PCSrc_t src, input word_t tgt,
                                input logic hit, input word_t ins, input logic e_ren,
                                input word_t e_addr, e_ins, e_npc, input logic e_v);
        vec_t v;
        v.rst = rst; v.pe = pe; v.p1 = p1; v.fl = fl; v.src = src; v.tgt = tgt;
        v.hit = hit; v.ins = ins; v.e_ren = e_ren; v.e_addr = e_addr;
        v.e_ins = e_ins; v.e_npc = e_npc; v.e_v = e_v;
        return v;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Unselected targets carry distinct junk so a wrong mux leg is visible
    task automatic drive(input logic rst, pe, p1, fl, input PCSrc_t src, input word_t tgt,
                         input logic hit, input word_t ins);
        RST         = rst;
        pc_en       = pe;
        pipe1_en    = p1;
        flushed1    = fl;
        pc_src      = src;
        branch_addr = (src == PC_BRANCH) ? tgt : 32'hBAD0_0000;
        jump_addr   = (src == PC_JUMP)   ? tgt : 32'hBAD1_0000;
        jr_addr     = (src == PC_JR)     ? tgt : 32'hBAD2_0000;
        ihit        = hit;
        imemload    = ins;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        btb_wen    = 1'b0;
        btb_pc     = 32'h0000_0000;
        btb_target = 32'h0000_0000;
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NEXT, 32'h0, 1'b0, 32'h0);

        vecs[0]  = mk(1, 0, 0, 0, PC_NEXT,   32'h0,   0, 32'h0,        1, 32'h000, 32'h0,        32'h000, 0);
        vecs[1]  = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A0, 1, 32'h004, 32'h2000_00A0, 32'h004, 1);
        vecs[2]  = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A1, 1, 32'h008, 32'h2000_00A1, 32'h008, 1);
        vecs[3]  = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A2, 1, 32'h00C, 32'h2000_00A2, 32'h00C, 1);
        vecs[4]  = mk(0, 1, 1, 0, PC_JUMP,   32'h100, 0, 32'h2000_00A3, 1, 32'h100, 32'h0,        32'h010, 0);
        vecs[5]  = mk(0, 0, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A3, 1, 32'h100, 32'h0,        32'h104, 0);
        vecs[6]  = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A4, 1, 32'h104, 32'h2000_00A4, 32'h104, 1);
        vecs[7]  = mk(0, 0, 0, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A5, 1, 32'h104, 32'h2000_00A4, 32'h104, 1);
        vecs[8]  = mk(0, 0, 0, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A5, 1, 32'h104, 32'h2000_00A4, 32'h104, 1);
        vecs[9]  = mk(0, 0, 0, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A5, 1, 32'h104, 32'h2000_00A4, 32'h104, 1);
        vecs[10] = mk(0, 0, 1, 0, PC_BRANCH, 32'h200, 0, 32'h0,        1, 32'h104, 32'h0,        32'h108, 0);
        vecs[11] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A6, 1, 32'h108, 32'h2000_00A6, 32'h108, 1);
        vecs[12] = mk(0, 1, 1, 0, PC_BRANCH, 32'h300, 1, 32'h2000_00A7, 1, 32'h300, 32'h2000_00A7, 32'h10C, 1);
        vecs[13] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A8, 1, 32'h304, 32'h2000_00A8, 32'h304, 1);
        vecs[14] = mk(0, 1, 1, 1, PC_NEXT,   32'h0,   1, 32'h2000_00A9, 1, 32'h308, 32'h0,        32'h000, 0);
        vecs[15] = mk(0, 1, 1, 0, PC_JR,     32'h400, 1, 32'h2000_00AA, 1, 32'h400, 32'h2000_00AA, 32'h30C, 1);
        vecs[16] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, HALT_W,        0, 32'h404, HALT_W,        32'h404, 1);
        vecs[17] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   0, 32'h0,        0, 32'h404, 32'h0,        32'h408, 0);
        vecs[18] = mk(0, 1, 1, 1, PC_BRANCH, 32'h040, 0, 32'h0,        1, 32'h040, 32'h0,        32'h000, 0);
        vecs[19] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00AB, 1, 32'h044, 32'h2000_00AB, 32'h044, 1);
        vecs[20] = mk(0, 1, 1, 0, PC_JUMP,   32'h500, 0, 32'h0,        1, 32'h500, 32'h0,        32'h048, 0);
        vecs[21] = mk(1, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00AC, 1, 32'h000, 32'h0,        32'h000, 0);
        vecs[22] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00AD, 1, 32'h004, 32'h2000_00AD, 32'h004, 1);
        vecs[23] = mk(0, 1, 1, 0, PC_JUMP,   32'hFFFF_FFFC, 1, 32'h2000_00AE, 1, 32'hFFFF_FFFC, 32'h2000_00AE, 32'h008, 1);
        vecs[24] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00AF, 1, 32'h000, 32'h2000_00AF, 32'h000, 1);
        vecs[25] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, HALT_W,        0, 32'h004, HALT_W,        32'h004, 1);
        vecs[26] = mk(1, 0, 0, 0, PC_NEXT,   32'h0,   0, 32'h0,        1, 32'h000, 32'h0,        32'h000, 0);
        vecs[27] = mk(0, 1, 1, 0, PC_NEXT,   32'h0,   1, 32'h2000_00A0, 1, 32'h004, 32'h2000_00A0, 32'h004, 1);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].pe, vecs[i].p1, vecs[i].fl, vecs[i].src, vecs[i].tgt,
                  vecs[i].hit, vecs[i].ins);
            tick();
            chk($sformatf("row%0d.imemREN", i),    32'(imemREN),         32'(vecs[i].e_ren));
            chk($sformatf("row%0d.imemaddr", i),   imemaddr,             vecs[i].e_addr);
            chk($sformatf("row%0d.ifid_instr", i), ifid_instr,           vecs[i].e_ins);
            chk($sformatf("row%0d.ifid_npc", i),   ifid_npc,             vecs[i].e_npc);
            chk($sformatf("row%0d.ifid_valid", i), 32'(ifid_valid),      32'(vecs[i].e_v));
            chk($sformatf("row%0d.pred_taken", i), 32'(ifid_pred_taken), 32'h0);
        end

`ifdef FETCH_BTB_EN
        // Install 0x8 -> 0x80 while the pipe is stalled, then fetch up to 0x8
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NEXT, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, PC_NEXT, 32'h0, 1'b0, 32'h0);
        btb_wen    = 1'b1;
        btb_pc     = 32'h0000_0008;
        btb_target = 32'h0000_0080;
        tick();
        btb_wen = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, PC_NEXT, 32'h0, 1'b1, 32'h2000_00B0);
        tick();
        chk("btb.miss_at_0", imemaddr, 32'h004);
        tick();
        chk("btb.reach_8", imemaddr, 32'h008);
        tick();
        chk("btb.hit_addr", imemaddr, 32'h080);
        chk("btb.hit_pred", 32'(ifid_pred_taken), 32'h1);
        chk("btb.hit_npc",  ifid_npc, 32'h00C);
        // Reset must clear the entry
        drive(1'b1, 1'b0, 1'b0, 1'b0, PC_NEXT, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, PC_NEXT, 32'h0, 1'b1, 32'h2000_00B1);
        tick();
        tick();
        chk("btb.rst_reach_8", imemaddr, 32'h008);
        tick();
        chk("btb.rst_addr", imemaddr, 32'h00C);
        chk("btb.rst_pred", 32'(ifid_pred_taken), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
